// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
//
// Front-end stage of the single-issue core. Holds the program counter, fetches
// one 32-bit instruction at a time over a req/ack handshake, presents it (with
// decoded opcode/funct) to the control decoder, and resolves the next PC from
// the decoder's branch/jump controls and the ALU zero flag.
//
// Parameters
//   ADDR_W    PC / instruction address width (>= 28)
//   RESET_PC  word-aligned PC loaded on reset
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   stall                    hold the current instruction in DECODE
//   branch_on_eq/_neq, jump  decoder controls, sampled on DECODE exit
//   zero                     ALU zero flag for the instruction in DECODE
//   imem_req/addr            fetch request and address (address == pc)
//   imem_ack/rdata           single-cycle ack, rdata valid with the ack
//   instr, instr_valid       instruction register and its live flag
//   opcode, funct            instr[31:26], instr[5:0]
//   pc                       address of the current instruction
//   instr_count              retired instruction count (wraps at 2^32)
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
    parameter int unsigned       ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              branch_on_eq,
    input  logic              branch_on_neq,
    input  logic              jump,
    input  logic              zero,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    output logic [31:0]       instr,
    output logic              instr_valid,
    output logic [5:0]        opcode,
    output logic [5:0]        funct,
    output logic [ADDR_W-1:0] pc,
    output logic [31:0]       instr_count
);

    if (ADDR_W < 28) begin : g_addr_w_check
        $error("instr_fetch_unit: ADDR_W must be at least 28");
    end

    localparam logic [5:0]  OP_BEQ    = 6'b000100;
    localparam logic [5:0]  OP_BNE    = 6'b000101;
    localparam logic [5:0]  OP_J      = 6'b000010;
    localparam logic [31:0] NOP_INSTR = 32'hFC00_0000;

    // Bits of pc4 that survive a jump: everything above bit 27.
    localparam logic [ADDR_W-1:0] J_HI_MASK = ~ADDR_W'(32'h0FFF_FFFF);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [31:0]       instr_q, instr_d;
    logic              instr_valid_q, instr_valid_d;
    logic              imem_req_q, imem_req_d;
    logic [31:0]       instr_count_q, instr_count_d;
    // Low for the first cycle after reset release, so IDLE lasts one full
    // cycle with rst already low before the first fetch request.
    logic              out_of_rst_q, out_of_rst_d;

    logic [ADDR_W-1:0] pc4;
    logic [ADDR_W-1:0] br_off;
    logic [ADDR_W-1:0] br_target;
    logic [ADDR_W-1:0] j_target;
    logic [ADDR_W-1:0] next_pc;
    logic              take_br;
    logic              take_j;

    // -------------------------------------------------------------------------
    // Next-PC resolution (all arithmetic modulo 2^ADDR_W)
    // -------------------------------------------------------------------------
    always_comb begin
        pc4       = pc_q + ADDR_W'(4);
        br_off    = {{(ADDR_W-18){instr_q[15]}}, instr_q[15:0], 2'b00};
        br_target = pc4 + br_off;
        j_target  = (pc4 & J_HI_MASK) | ADDR_W'({instr_q[25:0], 2'b00});

        // Controls only count when the opcode actually is that kind of
        // instruction; a stray branch_on_eq on an R-type never redirects.
        take_br = (branch_on_eq  &  zero & (instr_q[31:26] == OP_BEQ)) |
                  (branch_on_neq & ~zero & (instr_q[31:26] == OP_BNE));
        take_j  = jump & (instr_q[31:26] == OP_J);

        if (take_br) begin
            next_pc = br_target;
        end else if (take_j) begin
            next_pc = j_target;
        end else begin
            next_pc = pc4;
        end
    end

    // -------------------------------------------------------------------------
    // FSM next-state and registered-output computation
    // -------------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        instr_d       = instr_q;
        instr_valid_d = instr_valid_q;
        imem_req_d    = imem_req_q;
        instr_count_d = instr_count_q;
        out_of_rst_d  = 1'b1;

        case (state_q)
            S_IDLE: begin
                instr_valid_d = 1'b0;
                if (out_of_rst_q) begin
                    state_d    = S_FETCH;
                    imem_req_d = 1'b1;
                end else begin
                    imem_req_d = 1'b0;
                end
            end

            S_FETCH: begin
                // Address is pc_q, which cannot change in FETCH, so it is
                // stable for the whole request.
                instr_valid_d = 1'b0;
                imem_req_d    = 1'b1;
                if (imem_ack) begin
                    instr_d       = imem_rdata;
                    state_d       = S_DECODE;
                    imem_req_d    = 1'b0;
                    instr_valid_d = 1'b1;
                end
            end

            S_DECODE: begin
                // Any imem_ack seen here is stale and deliberately ignored.
                instr_valid_d = 1'b1;
                imem_req_d    = 1'b0;
                if (!stall) begin
                    pc_d          = next_pc;
                    instr_count_d = instr_count_q + 32'd1;
                    state_d       = S_FETCH;
                    imem_req_d    = 1'b1;
                    instr_valid_d = 1'b0;
                end
            end

            default: begin
                state_d       = S_IDLE;
                imem_req_d    = 1'b0;
                instr_valid_d = 1'b0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            pc_q          <= RESET_PC;
            instr_q       <= NOP_INSTR;
            instr_valid_q <= 1'b0;
            imem_req_q    <= 1'b0;
            instr_count_q <= '0;
            out_of_rst_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            instr_valid_q <= instr_valid_d;
            imem_req_q    <= imem_req_d;
            instr_count_q <= instr_count_d;
            out_of_rst_q  <= out_of_rst_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign imem_req    = imem_req_q;
    assign imem_addr   = pc_q;
    assign pc          = pc_q;
    assign instr       = instr_q;
    assign instr_valid = instr_valid_q;
    assign instr_count = instr_count_q;
    assign opcode      = instr_q[31:26];
    assign funct       = instr_q[5:0];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch_unit
//
// Directed bench for instr_fetch_unit. A table of instruction transactions
// (fetch address, returned word, wait states, stall length, decoder controls,
// expected next PC) walks the PC through sequential, branch, jump and wrap
// cases; hand-written sequences cover boot and mid-operation reset.
// Inputs change on the falling edge, outputs are sampled there too.
// -----------------------------------------------------------------------------
module tb_instr_fetch_unit;

    localparam int unsigned ADDR_W = 32;
    localparam logic [31:0] RST_PC = 32'h0000_0100;
    localparam logic [31:0] NOP    = 32'hFC00_0000;
    localparam logic [31:0] ADD    = 32'h0109_5020;
    localparam int unsigned NVEC   = 22;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              stall = 1'b0;
    logic              branch_on_eq = 1'b0;
    logic              branch_on_neq = 1'b0;
    logic              jump = 1'b0;
    logic              zero = 1'b0;
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ack = 1'b0;
    logic [31:0]       imem_rdata = '0;
    logic [31:0]       instr;
    logic              instr_valid;
    logic [5:0]        opcode;
    logic [5:0]        funct;
    logic [ADDR_W-1:0] pc;
    logic [31:0]       instr_count;

    instr_fetch_unit #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RST_PC)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .branch_on_eq  (branch_on_eq),
        .branch_on_neq (branch_on_neq),
        .jump          (jump),
        .zero          (zero),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .instr         (instr),
        .instr_valid   (instr_valid),
        .opcode        (opcode),
        .funct         (funct),
        .pc            (pc),
        .instr_count   (instr_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] word;
        int unsigned wait_cyc;
        int unsigned stall_cyc;
        logic [3:0]  ctrl;   // {branch_on_eq, branch_on_neq, jump, zero}
        logic        spur;   // stray ack on the DECODE exit edge
        logic [31:0] nxt;
    } vec_t;

    vec_t        vecs [NVEC];
    int unsigned n_pass  = 0;
    int unsigned n_total = 0;
    logic [31:0] exp_count = '0;

    function automatic vec_t mk(input logic [31:0] addr, input logic [31:0] word,
                                input int unsigned wait_cyc, input int unsigned stall_cyc,
                                input logic [3:0] ctrl, input logic spur,
                                input logic [31:0] nxt);
        vec_t v;
        v.addr = addr; v.word = word; v.wait_cyc = wait_cyc; v.stall_cyc = stall_cyc;
        v.ctrl = ctrl; v.spur = spur; v.nxt = nxt;
        return v;
    endfunction

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Bounded wait for a fetch request; a timeout is a failed comparison.
    task automatic wait_req();
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (imem_req === 1'b1) begin
                seen = 1'b1;
                break;
            end
            step();
        end
        chk("req_seen", 32'(seen), 32'd1);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_req"},   32'(imem_req),    32'd0);
        chk({tag, "_pc"},    pc,               RST_PC);
        chk({tag, "_instr"}, instr,            NOP);
        chk({tag, "_valid"}, 32'(instr_valid), 32'd0);
        chk({tag, "_count"}, instr_count,      32'd0);
    endtask

    // One complete instruction transaction: fetch, optional wait states,
    // capture, optional stall, then DECODE exit with the given controls.
    task automatic run_vec(input vec_t v);
        logic [31:0] held;
        logic [31:0] w;
        w = v.word;
        wait_req();
        chk("fetch_addr",  imem_addr,        v.addr);
        chk("fetch_pc",    pc,               v.addr);
        chk("fetch_valid", 32'(instr_valid), 32'd0);
        held = instr;
        for (int unsigned k = 0; k < v.wait_cyc; k++) begin
            step();
            chk("wait_req",   32'(imem_req), 32'd1);
            chk("wait_addr",  imem_addr,     v.addr);
            chk("wait_instr", instr,         held);
        end
        imem_ack = 1'b1;
        imem_rdata = v.word;
        step();
        imem_ack = 1'b0;
        imem_rdata = '0;
        chk("cap_instr",  instr,            v.word);
        chk("cap_valid",  32'(instr_valid), 32'd1);
        chk("cap_req",    32'(imem_req),    32'd0);
        chk("cap_opcode", 32'(opcode),      32'(w[31:26]));
        chk("cap_funct",  32'(funct),       32'(w[5:0]));
        for (int unsigned k = 0; k < v.stall_cyc; k++) begin
            stall = 1'b1;
            step();
            chk("stall_pc",    pc,               v.addr);
            chk("stall_instr", instr,            v.word);
            chk("stall_valid", 32'(instr_valid), 32'd1);
            chk("stall_req",   32'(imem_req),    32'd0);
            chk("stall_count", instr_count,      exp_count);
        end
        stall = 1'b0;
        {branch_on_eq, branch_on_neq, jump, zero} = v.ctrl;
        imem_ack = v.spur;
        imem_rdata = v.spur ? 32'hDEAD_BEEF : 32'h0;
        step();
        {branch_on_eq, branch_on_neq, jump, zero} = 4'b0000;
        imem_ack = 1'b0;
        imem_rdata = '0;
        exp_count = exp_count + 32'd1;
        chk("next_pc",    pc,               v.nxt);
        chk("next_addr",  imem_addr,        v.nxt);
        chk("next_req",   32'(imem_req),    32'd1);
        chk("next_valid", 32'(instr_valid), 32'd0);
        chk("next_count", instr_count,      exp_count);
        chk("next_instr", instr,            v.word);
    endtask

    initial begin
        //                addr          word          wait stall {beq,bne,j,z} spur next
        vecs[0]  = mk(32'h0000_0100, 32'h0800_0000, 0, 0, 4'b0010, 1'b0, 32'h0000_0000);
        vecs[1]  = mk(32'h0000_0000, ADD,           0, 0, 4'b0000, 1'b0, 32'h0000_0004);
        vecs[2]  = mk(32'h0000_0004, ADD,           0, 0, 4'b0000, 1'b0, 32'h0000_0008);
        vecs[3]  = mk(32'h0000_0008, ADD,           0, 0, 4'b0000, 1'b0, 32'h0000_000C);
        vecs[4]  = mk(32'h0000_000C, ADD,           0, 0, 4'b0000, 1'b0, 32'h0000_0010);
        vecs[5]  = mk(32'h0000_0010, ADD,           3, 0, 4'b0000, 1'b1, 32'h0000_0014);
        vecs[6]  = mk(32'h0000_0014, ADD,           0, 5, 4'b0000, 1'b0, 32'h0000_0018);
        vecs[7]  = mk(32'h0000_0018, 32'h0800_0010, 0, 0, 4'b0010, 1'b0, 32'h0000_0040);
        vecs[8]  = mk(32'h0000_0040, 32'h1000_FFFE, 0, 0, 4'b1001, 1'b0, 32'h0000_003C);
        vecs[9]  = mk(32'h0000_003C, 32'h0800_0010, 0, 0, 4'b0010, 1'b0, 32'h0000_0040);
        vecs[10] = mk(32'h0000_0040, 32'h1000_FFFE, 0, 0, 4'b1000, 1'b0, 32'h0000_0044);
        vecs[11] = mk(32'h0000_0044, 32'h0800_0010, 0, 0, 4'b0010, 1'b0, 32'h0000_0040);
        vecs[12] = mk(32'h0000_0040, 32'h1400_0003, 0, 0, 4'b0100, 1'b0, 32'h0000_0050);
        vecs[13] = mk(32'h0000_0050, ADD,           0, 0, 4'b1001, 1'b0, 32'h0000_0054);
        vecs[14] = mk(32'h0000_0054, 32'h1000_FFFE, 0, 0, 4'b0100, 1'b0, 32'h0000_0058);
        vecs[15] = mk(32'h0000_0058, 32'h0800_0000, 0, 0, 4'b0010, 1'b0, 32'h0000_0000);
        vecs[16] = mk(32'h0000_0000, 32'h1000_FFFE, 0, 0, 4'b1001, 1'b0, 32'hFFFF_FFFC);
        vecs[17] = mk(32'hFFFF_FFFC, ADD,           0, 0, 4'b0000, 1'b0, 32'h0000_0000);
        vecs[18] = mk(32'h0000_0000, 32'h0BFF_FFFF, 0, 0, 4'b0010, 1'b0, 32'h0FFF_FFFC);
        vecs[19] = mk(32'h0FFF_FFFC, ADD,           1, 0, 4'b0000, 1'b0, 32'h1000_0000);
        vecs[20] = mk(32'h1000_0000, 32'h0800_0040, 0, 0, 4'b0010, 1'b0, 32'h1000_0100);
        vecs[21] = mk(32'h1000_0100, 32'h0800_0000, 0, 0, 4'b0000, 1'b0, 32'h1000_0104);

        // Boot: three reset cycles, one IDLE cycle, then the first request.
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_reset_state("boot");
        end
        rst = 1'b0;
        step();
        chk("boot_idle_req",   32'(imem_req),    32'd0);
        chk("boot_idle_valid", 32'(instr_valid), 32'd0);
        step();
        chk("boot_first_req",  32'(imem_req),    32'd1);
        chk("boot_first_addr", imem_addr,        RST_PC);

        for (int unsigned i = 0; i < NVEC; i++) begin
            run_vec(vecs[i]);
        end

        // Reset in FETCH coinciding with an ack: the ack must be discarded.
        chk("pre_rst_req", 32'(imem_req), 32'd1);
        rst = 1'b1;
        imem_ack = 1'b1;
        imem_rdata = 32'h1234_5678;
        step();
        rst = 1'b0;
        imem_ack = 1'b0;
        imem_rdata = '0;
        exp_count = '0;
        chk_reset_state("rst_fetch");
        step();
        chk("rst_fetch_idle_req", 32'(imem_req), 32'd0);
        chk("rst_fetch_instr",    instr,         NOP);

        // Reset during a stalled DECODE.
        wait_req();
        chk("rst_dec_addr", imem_addr, RST_PC);
        imem_ack = 1'b1;
        imem_rdata = ADD;
        step();
        imem_ack = 1'b0;
        imem_rdata = '0;
        stall = 1'b1;
        step();
        step();
        chk("rst_dec_stalled_valid", 32'(instr_valid), 32'd1);
        chk("rst_dec_stalled_instr", instr,            ADD);
        rst = 1'b1;
        step();
        rst = 1'b0;
        stall = 1'b0;
        chk_reset_state("rst_decode");

        // Recovery after reset: a normal transaction from RESET_PC.
        run_vec(mk(RST_PC, ADD, 0, 0, 4'b0000, 1'b0, RST_PC + 32'd4));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    // Global time limit so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, %0d/%0d checks passed", n_pass, n_total);
        $fatal(1, "timeout");
    end

endmodule
